// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared encodings for the pipeline hold controller: HoldFlag levels,
// interrupt-entry FSM states and the default watchdog limit.
package pipe_ctrl_pkg;

  localparam int HOLD_W          = 3;
  localparam int TIMEOUT_DEFAULT = 1024;

  typedef enum logic [HOLD_W-1:0] {
    HOLD_NONE  = 3'd0,
    HOLD_PC    = 3'd1,
    HOLD_IF    = 3'd2,
    HOLD_ID    = 3'd3,
    HOLD_EX    = 3'd4,
    HOLD_FLUSH = 3'd5
  } hold_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REDIRECT = 2'd3
  } ctrl_state_e;

  // Levels that freeze at least one stage without clearing anything.
  function automatic logic is_stall(input logic [HOLD_W-1:0] h);
    return (h >= HOLD_PC) && (h <= HOLD_EX);
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_if.sv
// Request/response bundle between the pipeline stages, the CLINT and the
// hold controller. The controller side uses the slave modport.
interface pipe_hold_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int HOLD_W = 3
);
  logic              LoadUseReqFromId;
  logic              MulDivBusyFromEx;
  logic              JumpReqFromEx;
  logic [DATA_W-1:0] JumpAddrFromEx;
  logic              MemBusyFromMem;
  logic              IntReqFromClint;
  logic [DATA_W-1:0] IntVectorFromClint;
  logic              IntAckToClint;
  logic [HOLD_W-1:0] HoldFlagToPipe;
  logic              JumpFlagToPc;
  logic [DATA_W-1:0] JumpAddrToPc;
  logic              StallTimeout;
  logic              StallTimeoutClr;

  modport slave (
    input  LoadUseReqFromId, MulDivBusyFromEx, JumpReqFromEx, JumpAddrFromEx,
           MemBusyFromMem, IntReqFromClint, IntVectorFromClint, StallTimeoutClr,
    output IntAckToClint, HoldFlagToPipe, JumpFlagToPc, JumpAddrToPc, StallTimeout
  );

  modport master (
    output LoadUseReqFromId, MulDivBusyFromEx, JumpReqFromEx, JumpAddrFromEx,
           MemBusyFromMem, IntReqFromClint, IntVectorFromClint, StallTimeoutClr,
    input  IntAckToClint, HoldFlagToPipe, JumpFlagToPc, JumpAddrToPc, StallTimeout
  );
endinterface

// File: rtl/pipe_hold_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles and raises a sticky timeout flag when
// the count reaches TIMEOUT; an explicit clear beats a same-cycle set.
module stall_watchdog #(
  parameter int HOLD_W  = pipe_ctrl_pkg::HOLD_W,
  parameter int TIMEOUT = pipe_ctrl_pkg::TIMEOUT_DEFAULT,
  parameter int CNT_W   = 11
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [HOLD_W-1:0] hold_i,
  input  logic              clr_i,
  output logic              timeout_o
);
  import pipe_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  always_comb begin
    cnt_d  = '0;
    flag_d = flag_q;
    if (is_stall(hold_i)) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    end
    if (cnt_d == LIMIT) begin
      flag_d = 1'b1;
    end
    if (clr_i) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Central pipeline sequencing controller: merges stage stall/jump/interrupt
// requests into one HoldFlag level and runs the interrupt-entry sequence.
module pipe_hold_ctrl #(
  parameter int DATA_W  = 64,
  parameter int HOLD_W  = pipe_ctrl_pkg::HOLD_W,
  parameter int TIMEOUT = pipe_ctrl_pkg::TIMEOUT_DEFAULT,
  parameter int CNT_W   = 11
) (
  input  logic Clk,
  input  logic Rst,
  pipe_hold_ctrl_if.slave bus
);
  import pipe_ctrl_pkg::*;

  ctrl_state_e       state_q, state_d;
  hold_e             hold_d;
  logic              jump_d;
  logic [DATA_W-1:0] jaddr_d;
  logic              ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    hold_d  = HOLD_NONE;
    jump_d  = 1'b0;
    jaddr_d = '0;
    ack_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.IntReqFromClint) begin
          hold_d  = HOLD_EX;
          state_d = bus.MemBusyFromMem ? ST_DRAIN : ST_FLUSH;
        end else if (bus.MemBusyFromMem) begin
          hold_d = HOLD_EX;
        end else if (bus.MulDivBusyFromEx) begin
          hold_d = HOLD_ID;
        end else if (bus.JumpReqFromEx) begin
          hold_d  = HOLD_FLUSH;
          jump_d  = 1'b1;
          jaddr_d = bus.JumpAddrFromEx;
        end else if (bus.LoadUseReqFromId) begin
          hold_d = HOLD_IF;
        end
      end
      ST_DRAIN: begin
        hold_d = HOLD_EX;
        if (!bus.MemBusyFromMem) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        hold_d  = HOLD_FLUSH;
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        hold_d  = HOLD_FLUSH;
        jump_d  = 1'b1;
        jaddr_d = bus.IntVectorFromClint;
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset is synchronous, so quiet the combinational outputs while it is held.
    if (!Rst) begin
      hold_d  = HOLD_NONE;
      jump_d  = 1'b0;
      jaddr_d = '0;
      ack_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.HoldFlagToPipe = hold_d;
  assign bus.JumpFlagToPc   = jump_d;
  assign bus.JumpAddrToPc   = jaddr_d;
  assign bus.IntAckToClint  = ack_q;

  stall_watchdog #(
    .HOLD_W (HOLD_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_wdog (
    .Clk      (Clk),
    .Rst      (Rst),
    .hold_i   (hold_d),
    .clr_i    (bus.StallTimeoutClr),
    .timeout_o(bus.StallTimeout)
  );

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed cycle-by-cycle vectors; expected outputs are queued by the driver
// and compared mid-cycle by an independent monitor.
module tb_pipe_hold_ctrl;

  localparam logic [63:0] IV = 64'h0000_0000_8000_0100;
  localparam logic [63:0] JA = 64'h0000_0000_8000_0040;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hold_ctrl_if #(.DATA_W(64), .HOLD_W(3)) bus ();

  pipe_hold_ctrl #(.DATA_W(64), .HOLD_W(3), .TIMEOUT(8), .CNT_W(4)) dut (
    .Clk(clk),
    .Rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  hold;
    logic        jf;
    logic [63:0] addr;
    logic        ack;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;

  // ctl = {rst, loaduse, muldiv, jump, membusy, intreq, clr}
  task automatic step(input logic [6:0] ctl, input logic [63:0] ja,
                      input logic [2:0] eh, input logic ejf, input logic [63:0] ea,
                      input logic eack, input logic eto);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst                     = ctl[6];
    bus.LoadUseReqFromId    = ctl[5];
    bus.MulDivBusyFromEx    = ctl[4];
    bus.JumpReqFromEx       = ctl[3];
    bus.MemBusyFromMem      = ctl[2];
    bus.IntReqFromClint     = ctl[1];
    bus.StallTimeoutClr     = ctl[0];
    bus.JumpAddrFromEx      = ja;
    e.cyc = cyc; e.hold = eh; e.jf = ejf; e.addr = ea; e.ack = eack; e.to = eto;
    q.push_back(e);
  endtask

  task automatic idle_n(input int n, input logic eto);
    for (int i = 0; i < n; i++) step(7'b1000000, 64'd0, 3'd0, 1'b0, 64'd0, 1'b0, eto);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (bus.HoldFlagToPipe === e.hold && bus.JumpFlagToPc === e.jf &&
          bus.JumpAddrToPc === e.addr && bus.IntAckToClint === e.ack &&
          bus.StallTimeout === e.to) begin
        passed++;
      end else begin
        $display("FAIL cycle%0d outputs: got hold=%0d jf=%0b addr=%h ack=%0b to=%0b, want hold=%0d jf=%0b addr=%h ack=%0b to=%0b",
                 e.cyc, bus.HoldFlagToPipe, bus.JumpFlagToPc, bus.JumpAddrToPc,
                 bus.IntAckToClint, bus.StallTimeout,
                 e.hold, e.jf, e.addr, e.ack, e.to);
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus.LoadUseReqFromId   = 1'b0;
    bus.MulDivBusyFromEx   = 1'b0;
    bus.JumpReqFromEx      = 1'b0;
    bus.JumpAddrFromEx     = '0;
    bus.MemBusyFromMem     = 1'b0;
    bus.IntReqFromClint    = 1'b1;
    bus.IntVectorFromClint = IV;
    bus.StallTimeoutClr    = 1'b0;

    // reset held with a pending interrupt, then accepted on the first free cycle
    step(7'b0000010, 64'd0, 3'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b0000010, 64'd0, 3'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1000010, 64'd0, 3'd4, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1000000, 64'd0, 3'd5, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1000000, 64'd0, 3'd5, 1'b1, IV,    1'b0, 1'b0);
    step(7'b1000000, 64'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
    idle_n(1, 1'b0);

    // priority: jump beats load-use; muldiv beats load-use; load-use alone
    step(7'b1101000, JA,    3'd5, 1'b1, JA,    1'b0, 1'b0);
    step(7'b1000000, 64'd0, 3'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1110000, 64'd0, 3'd3, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1100000, 64'd0, 3'd2, 1'b0, 64'd0, 1'b0, 1'b0);
    idle_n(1, 1'b0);

    // interrupt with MEM drain; jump/stall during the sequence ignored
    step(7'b1000110, 64'd0, 3'd4, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1000100, 64'd0, 3'd4, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1001000, JA,    3'd4, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1010000, 64'd0, 3'd5, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1000000, 64'd0, 3'd5, 1'b1, IV,    1'b0, 1'b0);
    step(7'b1000000, 64'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
    idle_n(1, 1'b0);

    // interrupt without drain, same-cycle jump discarded
    step(7'b1001010, 64'h1234, 3'd4, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1000010, 64'd0, 3'd5, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1000000, 64'd0, 3'd5, 1'b1, IV,    1'b0, 1'b0);
    step(7'b1000000, 64'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
    idle_n(1, 1'b0);

    // watchdog: flag rises after the 8th held cycle and is sticky
    for (int i = 0; i < 8; i++) step(7'b1010000, 64'd0, 3'd3, 1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(7'b1010000, 64'd0, 3'd3, 1'b0, 64'd0, 1'b0, 1'b1);
    idle_n(2, 1'b1);
    // clear coinciding with a fresh set, then saturation re-sets it
    for (int i = 0; i < 7; i++) step(7'b1010000, 64'd0, 3'd3, 1'b0, 64'd0, 1'b0, 1'b1);
    step(7'b1010001, 64'd0, 3'd3, 1'b0, 64'd0, 1'b0, 1'b1);
    step(7'b1010000, 64'd0, 3'd3, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1000000, 64'd0, 3'd0, 1'b0, 64'd0, 1'b0, 1'b1);
    step(7'b1000001, 64'd0, 3'd0, 1'b0, 64'd0, 1'b0, 1'b1);
    idle_n(1, 1'b0);

    // reset while draining aborts the sequence without an ack
    step(7'b1000110, 64'd0, 3'd4, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b1000100, 64'd0, 3'd4, 1'b0, 64'd0, 1'b0, 1'b0);
    step(7'b0000100, 64'd0, 3'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    idle_n(4, 1'b0);

    @(posedge clk);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
